multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the RV32I core: steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.

---
 rtl/multicycle_ctrl_pkg.sv | 57 +++++
 rtl/multicycle_ctrl_typedecode.sv | 23 ++
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencer.
package multicycle_ctrl_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PC_SRC_W = 2;
  localparam int unsigned TMO_W    = 8;

  // Sequencer states; encodings are visible on the debug port.
  typedef enum logic [STATE_W-1:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd7
  } state_t;

  // PC source select seen by the datapath mux.
  localparam logic [PC_SRC_W-1:0] PC_SRC_PLUS4  = 2'b00;
  localparam logic [PC_SRC_W-1:0] PC_SRC_PC_IMM = 2'b01;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JALR   = 2'b10;

  // Trap cause codes.
  localparam logic CAUSE_ILLEGAL     = 1'b0;
  localparam logic CAUSE_BUS_TIMEOUT = 1'b1;

  // RV32I base opcodes (inst[6:0]).
  localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;

  // One-hot instruction class flags produced by the type decoder.
  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic op_imm;
    logic op;
  } inst_class_t;

  // An opcode is legal when it falls into any recognised class.
  function automatic logic is_legal(input inst_class_t cls);
    return (cls != '0);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_typedecode.sv
// Classifies the instruction opcode into one-hot RV32I class flags.
module multicycle_ctrl_typedecode
  import multicycle_ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output inst_class_t         cls
);

  // Pure opcode match; unknown opcodes leave every flag clear.
  always_comb begin
    cls        = '0;
    cls.lui    = (opcode == OPC_LUI);
    cls.auipc  = (opcode == OPC_AUIPC);
    cls.jal    = (opcode == OPC_JAL);
    cls.jalr   = (opcode == OPC_JALR);
    cls.branch = (opcode == OPC_BRANCH);
    cls.load   = (opcode == OPC_LOAD);
    cls.store  = (opcode == OPC_STORE);
    cls.op_imm = (opcode == OPC_OP_IMM);
    cls.op     = (opcode == OPC_OP);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer with a shared memory port,
// bus-timeout watchdog and sticky trap state.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  input  logic                branch_taken,
  input  logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                reg_we,
  output logic                instret,
  output logic                trap,
  output logic                trap_cause,
  output logic [STATE_W-1:0]  state
);

  // Last count value at which a still-pending request times out.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_t           state_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic             trap_q;
  logic             trap_cause_q;
  inst_class_t      cls;
  logic             legal;
  logic             tmo_hit;

  multicycle_ctrl_typedecode u_typedecode (
    .opcode (opcode),
    .cls    (cls)
  );

  assign legal   = is_legal(cls);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  // State sequencing, timeout counting and sticky trap capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      tmo_cnt_q    <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (tmo_hit) begin
            state_q      <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_BUS_TIMEOUT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_DECODE: begin
          if (!stall) begin
            if (!legal) begin
              state_q      <= ST_TRAP;
              trap_q       <= 1'b1;
              trap_cause_q <= CAUSE_ILLEGAL;
            end else begin
              state_q <= ST_EXECUTE;
            end
          end
        end
        ST_EXECUTE: begin
          if (!stall) begin
            if (cls.branch) begin
              state_q   <= ST_FETCH;
              tmo_cnt_q <= '0;
            end else if (cls.load || cls.store) begin
              state_q   <= ST_MEM;
              tmo_cnt_q <= '0;
            end else begin
              state_q <= ST_WB;
            end
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            if (cls.store) begin
              state_q   <= ST_FETCH;
              tmo_cnt_q <= '0;
            end else begin
              state_q <= ST_WB;
            end
          end else if (tmo_hit) begin
            state_q      <= ST_TRAP;
            trap_q       <= 1'b1;
            trap_cause_q <= CAUSE_BUS_TIMEOUT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_WB: begin
          if (!stall) begin
            state_q   <= ST_FETCH;
            tmo_cnt_q <= '0;
          end
        end
        ST_TRAP: begin
          state_q <= ST_TRAP;
        end
        default: begin
          state_q   <= ST_FETCH;
          tmo_cnt_q <= '0;
        end
      endcase
    end
  end

  // Output decode from the registered state; handshake strobes follow mem_ready.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    reg_we       = 1'b0;
    instret      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
        end
        ST_EXECUTE: begin
          if (cls.branch) begin
            pc_src  = branch_taken ? PC_SRC_PC_IMM : PC_SRC_PLUS4;
            pc_we   = !stall;
            instret = !stall;
          end
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = cls.store;
          if (mem_ready && cls.store) begin
            pc_we   = 1'b1;
            instret = 1'b1;
          end
        end
        ST_WB: begin
          if (cls.jal) begin
            pc_src = PC_SRC_PC_IMM;
          end else if (cls.jalr) begin
            pc_src = PC_SRC_JALR;
          end
          reg_we  = !stall;
          pc_we   = !stall;
          instret = !stall;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Status outputs read as zero while reset is held.
  assign trap       = trap_q & ~rst;
  assign trap_cause = trap_cause_q & ~rst;
  assign state      = rst ? '0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       branch_taken;
  logic       stall;
  logic       mem_req;
  logic       mem_we;
  logic       mem_addr_sel;
  logic       ir_we;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       reg_we;
  logic       instret;
  logic       trap;
  logic       trap_cause;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int OP_ADDI = 'h13;
  localparam int OP_BEQ  = 'h63;
  localparam int OP_SW   = 'h23;
  localparam int OP_LW   = 'h03;
  localparam int OP_JAL  = 'h6F;
  localparam int OP_JALR = 'h67;
  localparam int OP_BAD  = 'h7F;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .instret      (instret),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int op, input int rdy, input int bt, input int stl);
    opcode       = 7'(op);
    mem_ready    = 1'(rdy);
    branch_taken = 1'(bt);
    stall        = 1'(stl);
    #1;
  endtask

  task automatic expect_o(input string tag, input int st, input int req, input int we,
                          input int asel, input int irwe, input int pcwe, input int src,
                          input int rwe, input int iret, input int trp, input int cause);
    logic [14:0] obs;
    logic [14:0] expv;
    obs  = {state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
            reg_we, instret, trap, trap_cause};
    expv = {3'(st), 1'(req), 1'(we), 1'(asel), 1'(irwe), 1'(pcwe), 2'(src),
            1'(rwe), 1'(iret), 1'(trp), 1'(cause)};
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b (state,req,we,asel,ir_we,pc_we,pc_src,reg_we,instret,trap,cause)",
             tag, obs, expv);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(OP_ADDI, 0, 0, 0);
    expect_o("reset_pre_edge",   0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    drive(OP_ADDI, 1, 0, 0);
    expect_o("reset_held",       0, 0,0,0, 0,0,0, 0,0, 0,0);
    tick();
    rst = 1'b0;

    // addi, mem_ready in 2nd FETCH cycle: states 0,0,1,2,4,0
    drive(OP_ADDI, 0, 0, 0); expect_o("addi_f1",   0, 1,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 1, 0, 0); expect_o("addi_f2",   0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 1, 0, 0); expect_o("addi_dec",  1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 0, 1, 0); expect_o("addi_ex",   2, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 0, 0, 0); expect_o("addi_wb",   4, 0,0,0, 0,1,0, 1,1, 0,0); tick();

    // beq taken, then not taken; stall in FETCH is ignored
    drive(OP_BEQ, 1, 0, 1);  expect_o("beq_f",     0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_BEQ, 0, 0, 0);  expect_o("beq_dec",   1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_BEQ, 0, 1, 0);  expect_o("beq_ex_t",  2, 0,0,0, 0,1,1, 0,1, 0,0); tick();
    drive(OP_BEQ, 1, 0, 0);  expect_o("beq2_f",    0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_BEQ, 0, 0, 0);  expect_o("beq2_dec",  1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_BEQ, 0, 0, 0);  expect_o("beq_ex_nt", 2, 0,0,0, 0,1,0, 0,1, 0,0); tick();

    // sw with ready on 4th MEM cycle (timeout boundary, ready wins)
    drive(OP_SW, 1, 0, 0);   expect_o("sw_f",      0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_SW, 0, 0, 0);   tick();
    drive(OP_SW, 0, 0, 0);   expect_o("sw_ex",     2, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_SW, 0, 0, 1); expect_o("sw_mem_wait", 3, 1,1,1, 0,0,0, 0,0, 0,0); tick();
    end
    drive(OP_SW, 1, 0, 0);   expect_o("sw_mem_rdy", 3, 1,1,1, 0,1,0, 0,1, 0,0); tick();

    // lw with ready on 4th MEM cycle, then WB
    drive(OP_LW, 1, 0, 0);   expect_o("lw_f",      0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_LW, 0, 0, 0);   tick();
    drive(OP_LW, 0, 0, 0);   tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_LW, 0, 0, 0); expect_o("lw_mem_wait", 3, 1,0,1, 0,0,0, 0,0, 0,0); tick();
    end
    drive(OP_LW, 1, 0, 0);   expect_o("lw_mem_rdy", 3, 1,0,1, 0,0,0, 0,0, 0,0); tick();
    drive(OP_LW, 0, 0, 0);   expect_o("lw_wb",     4, 0,0,0, 0,1,0, 1,1, 0,0); tick();

    // jal stalled 3 cycles in EXECUTE
    drive(OP_JAL, 1, 0, 0);  expect_o("jal_f",     0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_JAL, 0, 0, 0);  tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_JAL, 0, 0, 1); expect_o("jal_ex_stall", 2, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    end
    drive(OP_JAL, 0, 0, 0);  expect_o("jal_ex",    2, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_JAL, 0, 0, 0);  expect_o("jal_wb",    4, 0,0,0, 0,1,1, 1,1, 0,0); tick();

    // jalr with one stalled WB cycle
    drive(OP_JALR, 1, 0, 0); tick();
    drive(OP_JALR, 0, 0, 0); tick();
    drive(OP_JALR, 0, 0, 0); tick();
    drive(OP_JALR, 0, 0, 1); expect_o("jalr_wb_stall", 4, 0,0,0, 0,0,2, 0,0, 0,0); tick();
    drive(OP_JALR, 0, 0, 0); expect_o("jalr_wb",   4, 0,0,0, 0,1,2, 1,1, 0,0); tick();

    // FETCH ready on wait cycle 4: no trap
    for (int i = 0; i < 3; i++) begin
      drive(OP_ADDI, 0, 0, 0); expect_o("tmo_edge_wait", 0, 1,0,0, 0,0,0, 0,0, 0,0); tick();
    end
    drive(OP_ADDI, 1, 0, 0); expect_o("tmo_edge_rdy", 0, 1,0,0, 1,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 0, 0, 0); expect_o("tmo_edge_dec", 1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_ADDI, 0, 0, 0); tick();
    drive(OP_ADDI, 0, 0, 0); tick();

    // FETCH never ready: bus-timeout trap after 4 wait cycles
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADDI, 0, 0, 0); expect_o("tmo_wait", 0, 1,0,0, 0,0,0, 0,0, 0,0); tick();
    end
    drive(OP_ADDI, 1, 1, 0); expect_o("tmo_trap",  7, 0,0,0, 0,0,0, 0,0, 1,1); tick();
    drive(OP_ADDI, 1, 0, 0); expect_o("tmo_trap_hold", 7, 0,0,0, 0,0,0, 0,0, 1,1); tick();
    rst = 1'b1;
    drive(OP_ADDI, 0, 0, 0); expect_o("tmo_rst",   0, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    rst = 1'b0;
    drive(OP_BAD, 1, 0, 0);  expect_o("tmo_rst_f", 0, 1,0,0, 1,0,0, 0,0, 0,0); tick();

    // illegal opcode: stall in DECODE holds, then trap cause 0
    drive(OP_BAD, 0, 0, 1);  expect_o("ill_dec_stall", 1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_BAD, 0, 0, 0);  expect_o("ill_dec",   1, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    drive(OP_BAD, 1, 1, 0);  expect_o("ill_trap",  7, 0,0,0, 0,0,0, 0,0, 1,0); tick();
    drive(OP_ADDI, 1, 0, 1); expect_o("ill_trap_hold", 7, 0,0,0, 0,0,0, 0,0, 1,0); tick();
    rst = 1'b1;
    drive(OP_SW, 0, 0, 0);   tick();
    rst = 1'b0;
    drive(OP_SW, 0, 0, 0);   expect_o("ill_rst_f", 0, 1,0,0, 0,0,0, 0,0, 0,0); tick();

    // reset mid-store drops the MEM request and restarts at FETCH
    drive(OP_SW, 1, 0, 0);   tick();
    drive(OP_SW, 0, 0, 0);   tick();
    drive(OP_SW, 0, 0, 0);   tick();
    drive(OP_SW, 0, 0, 0);   expect_o("mid_mem",   3, 1,1,1, 0,0,0, 0,0, 0,0); tick();
    rst = 1'b1;
    drive(OP_SW, 0, 0, 0);   expect_o("mid_rst",   0, 0,0,0, 0,0,0, 0,0, 0,0); tick();
    rst = 1'b0;
    drive(OP_SW, 0, 0, 0);   expect_o("mid_restart", 0, 1,0,0, 0,0,0, 0,0, 0,0); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
